// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART FIFO read-side logic.
// Contents:
//   UART_DATA_W / UART_GAP_W / UART_CNT_W  default widths for data, gap timer and frame counter
//   tx_seq_state_e                         3-bit state encoding of fifo_tx_sequencer
package uart_fifo_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned UART_GAP_W  = 8;
  localparam int unsigned UART_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP     = 3'd1,
    CAPTURE = 3'd2,
    OFFER   = 3'd3,
    GAP     = 3'd4
  } tx_seq_state_e;

endpackage

// File: rtl/tx_gap_timer.sv
// Inter-frame gap down-counter for fifo_tx_sequencer.
// Ports:
//   rclk, rrst  clock and asynchronous active-high reset (counter resets to 0)
//   load        load load_val into the counter (takes priority over dec)
//   load_val    gap length in rclk cycles
//   dec         decrement by one; the counter holds at 0
//   done        counter equals 1, i.e. the current cycle is the last gap cycle
module tx_gap_timer #(
  parameter int unsigned GAP_W = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [GAP_W-1:0] cnt_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - GAP_W'(1);
    end
  end

  assign done = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/fifo_tx_sequencer.sv
// Read-side controller of the UART async FIFO (rclk domain). Pops one byte at a time from the
// FIFO, offers it to the UART TX serializer over valid/ready, inserts a programmable idle gap
// after every accepted byte and counts accepted frames.
// Ports:
//   rclk, rrst   read clock and asynchronous active-high reset
//   enable       allows new pops to start; a byte already popped is always delivered
//   gap_cycles   idle cycles after each accepted byte, sampled when the gap starts (0 = none)
//   fifo_empty   FIFO empty flag
//   fifo_rdata   FIFO read data, valid one rclk after fifo_rinc
//   fifo_rinc    single-cycle FIFO read increment
//   tx_ready     serializer can accept a byte
//   tx_valid     tx_data is valid
//   tx_data      byte offered to the serializer
//   busy         high whenever the sequencer is not idle
//   frame_cnt    accepted byte count, wraps silently
//   cts_n        (only with FIFO_TX_SEQ_CTS_FLOW_EN) active-low clear-to-send, asynchronous
// Build option: define FIFO_TX_SEQ_CTS_FLOW_EN to add cts_n flow control on new pops.
module fifo_tx_sequencer
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = UART_DATA_W,
  parameter int unsigned GAP_W = UART_GAP_W,
  parameter int unsigned CNT_W = UART_CNT_W
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rinc,
  input  logic             tx_ready,
`ifdef FIFO_TX_SEQ_CTS_FLOW_EN
  input  logic             cts_n,
`endif
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  tx_seq_state_e state_q;
  logic          cts_ok;
  logic          gap_load;
  logic          gap_dec;
  logic          gap_done;

`ifdef FIFO_TX_SEQ_CTS_FLOW_EN
  // Two-flop synchronizer; resets to "not clear to send".
  logic [1:0] cts_sync_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cts_sync_q <= 2'b11;
    end else begin
      cts_sync_q <= {cts_sync_q[0], cts_n};
    end
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  // The gap length is captured on the handshake edge, which is also the GAP entry edge.
  assign gap_load = (state_q == OFFER) && tx_ready;
  assign gap_dec  = (state_q == GAP);

  tx_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .rclk     (rclk),
    .rrst     (rrst),
    .load     (gap_load),
    .load_val (gap_cycles),
    .dec      (gap_dec),
    .done     (gap_done)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q   <= IDLE;
      fifo_rinc <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && !fifo_empty && cts_ok) begin
            state_q   <= POP;
            fifo_rinc <= 1'b1;
            busy      <= 1'b1;
          end
        end
        POP: begin
          fifo_rinc <= 1'b0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          tx_data  <= fifo_rdata;
          tx_valid <= 1'b1;
          state_q  <= OFFER;
        end
        OFFER: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            frame_cnt <= frame_cnt + CNT_W'(1);
            if (gap_cycles != '0) begin
              state_q <= GAP;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          fifo_rinc <= 1'b0;
          tx_valid  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_sequencer.sv
// Self-checking bench for fifo_tx_sequencer. A queue models the FIFO (registered read data),
// a second queue holds the bytes that must come out in order, and a monitor checks the
// handshake protocol, byte order, frame count and latency. The frame counter is built
// 8 bits wide so that its wrap can be reached with real transfers.
module tb_fifo_tx_sequencer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MOD = 1 << CNT_W;

  logic             rclk       = 1'b0;
  logic             rrst       = 1'b1;
  logic             enable     = 1'b0;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             fifo_rinc;
  logic             tx_ready   = 1'b0;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
`ifdef FIFO_TX_SEQ_CTS_FLOW_EN
  logic             cts_n      = 1'b0;
`endif

  fifo_tx_sequencer #(
    .WIDTH (WIDTH),
    .GAP_W (GAP_W),
    .CNT_W (CNT_W)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .enable     (enable),
    .gap_cycles (gap_cycles),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rinc  (fifo_rinc),
    .tx_ready   (tx_ready),
`ifdef FIFO_TX_SEQ_CTS_FLOW_EN
    .cts_n      (cts_n),
`endif
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // FIFO model: read data appears one rclk after the increment. The DUT never samples
  // fifo_rdata or fifo_empty on the edge that pops, so blocking updates here are safe.
  logic [WIDTH-1:0] fq[$];
  always @(posedge rclk) begin
    if (fifo_rinc) begin
      check("rinc_nonempty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) fifo_rdata = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  end

  // Reference model and protocol monitor.
  logic [WIDTH-1:0] exp_q[$];
  int               rinc_q[$];
  int               hs_q[$];
  int               cyc = 0, pops = 0, hs = 0, model_cnt = 0, last_rinc = 0;
  int               valid_cycles = 0, busy_cycles = 0;
  logic             prev_valid = 1'b0, prev_hs = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(posedge rclk) begin
    cyc++;
    if (!rrst) begin
      if (fifo_rinc) begin
        check("one_outstanding", 32'(pops - hs), 32'd0);
        pops++;
        last_rinc = cyc;
        rinc_q.push_back(cyc);
      end
      if (tx_valid && !prev_valid) check("rinc_to_valid", 32'(cyc - last_rinc), 32'd2);
      if (tx_valid && prev_valid && !prev_hs) check("data_stable", 32'(tx_data), 32'(prev_data));
      check("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
      if (tx_valid) valid_cycles++;
      if (busy) busy_cycles++;
      prev_hs = tx_valid && tx_ready;
      if (prev_hs) begin
        if (exp_q.size() == 0) check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        else check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        hs++;
        model_cnt = (model_cnt + 1) % CNT_MOD;
        hs_q.push_back(cyc);
      end
      prev_valid = tx_valid;
      prev_data  = tx_data;
    end
  end

  // A byte popped but not yet accepted is lost on reset.
  task automatic model_reset();
    if (pops > hs) void'(exp_q.pop_front());
    pops = 0; hs = 0; model_cnt = 0;
    prev_valid = 1'b0; prev_hs = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst = 1'b1;
    model_reset();
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic clear_obs();
    rinc_q.delete(); hs_q.delete();
    valid_cycles = 0; busy_cycles = 0;
  endtask

  task automatic push(input logic [WIDTH-1:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !tx_valid; i++) @(negedge rclk);
    check("wait_valid", 32'(tx_valid), 32'd1);
  endtask

  task automatic wait_rinc(input int bound);
    for (int i = 0; i < bound && !fifo_rinc; i++) @(negedge rclk);
    check("wait_rinc", 32'(fifo_rinc), 32'd1);
  endtask

  task automatic wait_hs(input int n, input int bound);
    for (int i = 0; i < bound && hs < n; i++) @(negedge rclk);
    check("wait_hs", 32'(hs), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int t0;
    int d;
    logic done;

    // Reset state.
    repeat (2) @(negedge rclk);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rinc", 32'(fifo_rinc), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    rrst = 1'b0;

    // Single byte.
    enable = 1'b1; tx_ready = 1'b1; gap_cycles = '0;
    clear_obs();
    @(negedge rclk);
    t0 = cyc;
    push(8'hA5);
    run(8);
    check("t1_rinc_count", 32'(rinc_q.size()), 32'd1);
    check("t1_rinc_lat", 32'(rinc_q[0] - t0), 32'd2);
    check("t1_hs_lat", 32'(hs_q[0] - t0), 32'd4);
    check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_tx_valid", 32'(tx_valid), 32'd0);

    // Backpressure.
    do_reset();
    clear_obs();
    tx_ready = 1'b0;
    push(8'h3C);
    wait_valid(20);
    run(10);
    tx_ready = 1'b1;
    run(5);
    check("t2_valid_cycles", 32'(valid_cycles), 32'd11);
    check("t2_rinc_count", 32'(rinc_q.size()), 32'd1);
    check("t2_hs_count", 32'(hs_q.size()), 32'd1);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd1);

    // Gap and throughput.
    do_reset();
    clear_obs();
    gap_cycles = 8'd5;
    for (int i = 1; i <= 4; i++) push(8'(i));
    run(45);
    check("t3_rinc_count", 32'(rinc_q.size()), 32'd4);
    for (int i = 1; i < 4; i++) check("t3_gap_spacing", 32'(rinc_q[i] - rinc_q[i-1]), 32'd9);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd4);
    check("t3_busy_cycles", 32'(busy_cycles), 32'd32);
    clear_obs();
    gap_cycles = '0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    run(25);
    check("t3_rinc_count0", 32'(rinc_q.size()), 32'd4);
    for (int i = 1; i < 4; i++) check("t3_spacing0", 32'(rinc_q[i] - rinc_q[i-1]), 32'd4);
    check("t3_frame_cnt0", 32'(frame_cnt), 32'd8);
    check("t3_busy_cycles0", 32'(busy_cycles), 32'd12);

    // Enable drop mid-flight.
    do_reset();
    clear_obs();
    push(8'h55); push(8'h66);
    wait_rinc(20);
    @(negedge rclk);
    enable = 1'b0;
    run(20);
    check("t4_hs_count", 32'(hs_q.size()), 32'd1);
    check("t4_rinc_count", 32'(rinc_q.size()), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    run(10);
    check("t4_hs_resume", 32'(hs_q.size()), 32'd2);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd2);

    // Reset while a byte is offered.
    do_reset();
    push(8'h11);
    run(6);
    tx_ready = 1'b0;
    push(8'h77); push(8'h88);
    wait_valid(20);
    #2 rrst = 1'b1;
    model_reset();
    #1;
    check("t5_tx_valid", 32'(tx_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_tx_data", 32'(tx_data), 32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    clear_obs();
    tx_ready = 1'b1;
    run(10);
    check("t5_rinc_count", 32'(rinc_q.size()), 32'd1);
    check("t5_frame_cnt_after", 32'(frame_cnt), 32'd1);

    // Frame counter wrap.
    do_reset();
    for (int i = 0; i < CNT_MOD - 1; i++) push(8'($urandom));
    wait_hs(CNT_MOD - 1, 2000);
    run(1);
    check("t6_cnt_max", 32'(frame_cnt), 32'(CNT_MOD - 1));
    push(8'($urandom));
    wait_hs(CNT_MOD, 20);
    run(1);
    check("t6_cnt_wrap", 32'(frame_cnt), 32'd0);

    // Empty guard.
    clear_obs();
    run(100);
    check("t6_empty_guard", 32'(rinc_q.size()), 32'd0);

`ifdef FIFO_TX_SEQ_CTS_FLOW_EN
    clear_obs();
    cts_n = 1'b1;
    run(4);
    push(8'hC3);
    run(10);
    check("cts_block", 32'(rinc_q.size()), 32'd0);
    t0 = cyc;
    cts_n = 1'b0;
    run(10);
    d = rinc_q[0] - t0;
    check("cts_resume", 32'(d >= 3 && d <= 4), 32'd1);
    check("cts_hs", 32'(hs_q.size()), 32'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 16) push(8'($urandom));
      tx_ready = ($urandom_range(0, 3) != 0);
      enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) gap_cycles = 8'($urandom_range(0, 3));
      @(negedge rclk);
    end
    enable = 1'b1; tx_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge rclk);
      done = (fq.size() == 0) && (exp_q.size() == 0) && !busy;
    end
    check("rand_drained", 32'(done), 32'd1);
    check("rand_pops_eq_hs", 32'(pops - hs), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
